// File: rtl/mc_control_fsm.sv
// mc_control_fsm -- multicycle MIPS control unit (main FSM + ALU decode).
//
// Drives the datapath muxes and write enables of the multicycle core from
// the instruction register fields. Moore outputs decoded from the state,
// except PCEn which also folds in the ALU Zero flag for branches.
//
// Parameters:
//   ALUCTRL_W  width of ALUControl (>= 3, codes zero-extended above bit 2)
//   MEM_LAT    extra wait cycles in FETCH / MEMRD / MEMWR (0..15)
//
// Optional feature macro: MC_BNE_EN -- when defined, opcode 0x05 (bne)
// branches on ~Zero; when undefined, 0x05 is reported as illegal.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   Opcode, Funct     IR[31:26], IR[5:0]
//   Zero              ALU zero flag
//   MemtoReg, RegDst, IorD, ALUSrcA, ALUSrcB[1:0], PCSrc[1:0], ZeroExt
//                     datapath mux selects
//   IRWrite, MemWrite, RegWrite, PCEn
//                     write enables (forced low while rst is high)
//   ALUControl        ALU operation
//   Illegal           one-cycle pulse on an unknown opcode in DECODE
//   State             current state (debug)
`timescale 1ns/1ps

module mc_control_fsm #(
    parameter int ALUCTRL_W = 3,
    parameter int MEM_LAT   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           Opcode,
    input  logic [5:0]           Funct,
    input  logic                 Zero,
    output logic                 MemtoReg,
    output logic                 RegDst,
    output logic                 IorD,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           PCSrc,
    output logic                 ZeroExt,
    output logic                 IRWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 PCEn,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 Illegal,
    output logic [3:0]           State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEXE = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t     state_q, state_d;
    logic [3:0] cnt_q;
    logic       mem_state, mem_last;
    logic       pcwrite, branch, bcond;
    logic [2:0] alu_op;

    function automatic logic [2:0] funct_op(input logic [5:0] f);
        case (f)
            6'h20:   return ALU_ADD;
            6'h22:   return ALU_SUB;
            6'h24:   return ALU_AND;
            6'h25:   return ALU_OR;
            6'h2A:   return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    // Memory-access states hold until the wait counter reaches MEM_LAT.
    always_comb begin
        mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        mem_last  = mem_state && (cnt_q == LAT);
    end

    always_comb begin
`ifdef MC_BNE_EN
        bcond = (Opcode == OP_BNE) ? ~Zero : Zero;
`else
        bcond = Zero;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            // Every state exit happens on a cycle where either the state is
            // not a memory state or mem_last is true, so this clears on entry.
            if (mem_state && !mem_last)
                cnt_q <= cnt_q + 4'd1;
            else
                cnt_q <= '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        MemtoReg = 1'b0;
        RegDst   = 1'b0;
        IorD     = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        PCSrc    = 2'b00;
        ZeroExt  = 1'b0;
        IRWrite  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        Illegal  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        alu_op   = ALU_AND;

        case (state_q)
            S_FETCH: begin
                ALUSrcB = 2'b01;
                alu_op  = ALU_ADD;
                if (mem_last) begin
                    IRWrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                alu_op  = ALU_ADD;
                case (Opcode)
                    OP_LW, OP_SW:           state_d = S_MEMADR;
                    OP_R:                   state_d = S_RTEXE;
                    OP_BEQ:                 state_d = S_BRANCH;
`ifdef MC_BNE_EN
                    OP_BNE:                 state_d = S_BRANCH;
`endif
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMMEXE;
                    OP_J:                   state_d = S_JUMP;
                    default: begin
                        Illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                alu_op  = ALU_ADD;
                state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD = 1'b1;
                if (mem_last) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                IorD = 1'b1;
                if (mem_last) begin
                    MemWrite = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_RTEXE: begin
                ALUSrcA = 1'b1;
                alu_op  = funct_op(Funct);
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = ALU_SUB;
                PCSrc   = 2'b01;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_IMMEXE, S_IMMWB: begin
                case (Opcode)
                    OP_ANDI: begin alu_op = ALU_AND; ZeroExt = 1'b1; end
                    OP_ORI:  begin alu_op = ALU_OR;  ZeroExt = 1'b1; end
                    default: alu_op = ALU_ADD;
                endcase
                if (state_q == S_IMMEXE) begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    state_d = S_IMMWB;
                end else begin
                    RegWrite = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_JUMP: begin
                PCSrc   = 2'b10;
                pcwrite = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        PCEn = pcwrite | (branch & bcond);

        // Write strobes are suppressed for the whole reset pulse so that an
        // asynchronous reset mid-instruction never leaves a partial write.
        if (rst) begin
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            PCEn     = 1'b0;
            Illegal  = 1'b0;
        end

        ALUControl      = '0;
        ALUControl[2:0] = alu_op;
        State           = state_q;
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Testbench for mc_control_fsm: one instance with MEM_LAT=0 driven from a
// cycle-by-cycle vector table, one with MEM_LAT=2 for wait-state sequences.
`timescale 1ns/1ps

module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Opcode, Funct;
    logic       Zero;

    always #5 clk = ~clk;

    // MEM_LAT = 0 instance
    logic       MemtoReg0, RegDst0, IorD0, ALUSrcA0, ZeroExt0;
    logic       IRWrite0, MemWrite0, RegWrite0, PCEn0, Illegal0;
    logic [1:0] ALUSrcB0, PCSrc0;
    logic [2:0] ALUControl0;
    logic [3:0] State0;

    // MEM_LAT = 2 instance
    logic       MemtoReg2, RegDst2, IorD2, ALUSrcA2, ZeroExt2;
    logic       IRWrite2, MemWrite2, RegWrite2, PCEn2, Illegal2;
    logic [1:0] ALUSrcB2, PCSrc2;
    logic [2:0] ALUControl2;
    logic [3:0] State2;

    mc_control_fsm #(.ALUCTRL_W(3), .MEM_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .MemtoReg(MemtoReg0), .RegDst(RegDst0), .IorD(IorD0), .ALUSrcA(ALUSrcA0),
        .ALUSrcB(ALUSrcB0), .PCSrc(PCSrc0), .ZeroExt(ZeroExt0), .IRWrite(IRWrite0),
        .MemWrite(MemWrite0), .RegWrite(RegWrite0), .PCEn(PCEn0),
        .ALUControl(ALUControl0), .Illegal(Illegal0), .State(State0)
    );

    mc_control_fsm #(.ALUCTRL_W(3), .MEM_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .MemtoReg(MemtoReg2), .RegDst(RegDst2), .IorD(IorD2), .ALUSrcA(ALUSrcA2),
        .ALUSrcB(ALUSrcB2), .PCSrc(PCSrc2), .ZeroExt(ZeroExt2), .IRWrite(IRWrite2),
        .MemWrite(MemWrite2), .RegWrite(RegWrite2), .PCEn(PCEn2),
        .ALUControl(ALUControl2), .Illegal(Illegal2), .State(State2)
    );

    // {State, IRWrite, MemWrite, RegWrite, PCEn, Illegal, RegDst, MemtoReg,
    //  IorD, ALUSrcA, ALUSrcB, PCSrc, ZeroExt, ALUControl}
    logic [20:0] act0;
    assign act0 = {State0, IRWrite0, MemWrite0, RegWrite0, PCEn0, Illegal0,
                   RegDst0, MemtoReg0, IorD0, ALUSrcA0, ALUSrcB0, PCSrc0,
                   ZeroExt0, ALUControl0};

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic [20:0] exp;
    } vec_t;

    typedef struct {
        logic [5:0] op;
        logic [3:0] st;
        logic       irw;
        logic       mw;
        logic       rw;
    } seq_t;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    vec_t        tbl[$];
    seq_t        seq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                input logic [3:0] st, input logic irw, input logic mw,
                                input logic rw, input logic pcen, input logic ill,
                                input logic rd, input logic m2r, input logic iord,
                                input logic sa, input logic [1:0] sb, input logic [1:0] ps,
                                input logic ze, input logic [2:0] alu);
        vec_t v;
        v.op  = op;
        v.fn  = fn;
        v.z   = z;
        v.exp = {st, irw, mw, rw, pcen, ill, rd, m2r, iord, sa, sb, ps, ze, alu};
        return v;
    endfunction

    function automatic vec_t fe(input logic [5:0] op, input logic [5:0] fn, input logic z);
        return mk(op, fn, z, 4'd0, 1,0,0,1,0, 0,0,0,0, 2'b01, 2'b00, 0, 3'b010);
    endfunction

    function automatic vec_t de(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                input logic ill);
        return mk(op, fn, z, 4'd1, 0,0,0,0,ill, 0,0,0,0, 2'b11, 2'b00, 0, 3'b010);
    endfunction

    function automatic vec_t ma(input logic [5:0] op);
        return mk(op, 6'h00, 0, 4'd2, 0,0,0,0,0, 0,0,0,1, 2'b10, 2'b00, 0, 3'b010);
    endfunction

    task automatic rtype(input logic [5:0] fn, input logic [2:0] alu);
        tbl.push_back(fe(6'h00, fn, 0));
        tbl.push_back(de(6'h00, fn, 0, 0));
        tbl.push_back(mk(6'h00, fn, 0, 4'd6, 0,0,0,0,0, 0,0,0,1, 2'b00, 2'b00, 0, alu));
        tbl.push_back(mk(6'h00, fn, 0, 4'd7, 0,0,1,0,0, 1,0,0,0, 2'b00, 2'b00, 0, 3'b000));
    endtask

    task automatic imm(input logic [5:0] op, input logic ze, input logic [2:0] alu);
        tbl.push_back(fe(op, 6'h00, 0));
        tbl.push_back(de(op, 6'h00, 0, 0));
        tbl.push_back(mk(op, 6'h00, 0, 4'd9,  0,0,0,0,0, 0,0,0,1, 2'b10, 2'b00, ze, alu));
        tbl.push_back(mk(op, 6'h00, 0, 4'd10, 0,0,1,0,0, 0,0,0,0, 2'b00, 2'b00, ze, alu));
    endtask

    task automatic push_seq(input logic [5:0] op, input logic [3:0] st, input logic irw,
                            input logic mw, input logic rw);
        seq_t s;
        s.op = op; s.st = st; s.irw = irw; s.mw = mw; s.rw = rw;
        seq.push_back(s);
    endtask

    initial begin
        rst    = 1'b1;
        Opcode = 6'h00;
        Funct  = 6'h00;
        Zero   = 1'b0;

        // sw
        tbl.push_back(fe(6'h2B, 6'h00, 0));
        tbl.push_back(de(6'h2B, 6'h00, 0, 0));
        tbl.push_back(ma(6'h2B));
        tbl.push_back(mk(6'h2B, 6'h00, 0, 4'd5, 0,1,0,0,0, 0,0,1,0, 2'b00, 2'b00, 0, 3'b000));
        // lw
        tbl.push_back(fe(6'h23, 6'h00, 0));
        tbl.push_back(de(6'h23, 6'h00, 0, 0));
        tbl.push_back(ma(6'h23));
        tbl.push_back(mk(6'h23, 6'h00, 0, 4'd3, 0,0,0,0,0, 0,0,1,0, 2'b00, 2'b00, 0, 3'b000));
        tbl.push_back(mk(6'h23, 6'h00, 0, 4'd4, 0,0,1,0,0, 0,1,0,0, 2'b00, 2'b00, 0, 3'b000));
        // R-type: slt, unknown funct falls back to add, sub
        rtype(6'h2A, 3'b111);
        rtype(6'h3F, 3'b010);
        rtype(6'h22, 3'b110);
        // beq taken / not taken
        tbl.push_back(fe(6'h04, 6'h00, 1));
        tbl.push_back(de(6'h04, 6'h00, 1, 0));
        tbl.push_back(mk(6'h04, 6'h00, 1, 4'd8, 0,0,0,1,0, 0,0,0,1, 2'b00, 2'b01, 0, 3'b110));
        tbl.push_back(fe(6'h04, 6'h00, 0));
        tbl.push_back(de(6'h04, 6'h00, 0, 0));
        tbl.push_back(mk(6'h04, 6'h00, 0, 4'd8, 0,0,0,0,0, 0,0,0,1, 2'b00, 2'b01, 0, 3'b110));
        // j
        tbl.push_back(fe(6'h02, 6'h00, 0));
        tbl.push_back(de(6'h02, 6'h00, 0, 0));
        tbl.push_back(mk(6'h02, 6'h00, 0, 4'd11, 0,0,0,1,0, 0,0,0,0, 2'b00, 2'b10, 0, 3'b000));
        // ori, andi, addi
        imm(6'h0D, 1, 3'b001);
        imm(6'h0C, 1, 3'b000);
        imm(6'h08, 0, 3'b010);
        // unknown opcode
        tbl.push_back(fe(6'h3F, 6'h00, 0));
        tbl.push_back(de(6'h3F, 6'h00, 0, 1));
        // bne with Zero=0
        tbl.push_back(fe(6'h05, 6'h00, 0));
`ifdef MC_BNE_EN
        tbl.push_back(de(6'h05, 6'h00, 0, 0));
        tbl.push_back(mk(6'h05, 6'h00, 0, 4'd8, 0,0,0,1,0, 0,0,0,1, 2'b00, 2'b01, 0, 3'b110));
`else
        tbl.push_back(de(6'h05, 6'h00, 0, 1));
`endif
        tbl.push_back(fe(6'h00, 6'h00, 0));

        // MEM_LAT=2: lw then sw
        push_seq(6'h23, 0, 0, 0, 0); push_seq(6'h23, 0, 0, 0, 0); push_seq(6'h23, 0, 1, 0, 0);
        push_seq(6'h23, 1, 0, 0, 0); push_seq(6'h23, 2, 0, 0, 0);
        push_seq(6'h23, 3, 0, 0, 0); push_seq(6'h23, 3, 0, 0, 0); push_seq(6'h23, 3, 0, 0, 0);
        push_seq(6'h23, 4, 0, 0, 1);
        push_seq(6'h2B, 0, 0, 0, 0); push_seq(6'h2B, 0, 0, 0, 0); push_seq(6'h2B, 0, 1, 0, 0);
        push_seq(6'h2B, 1, 0, 0, 0); push_seq(6'h2B, 2, 0, 0, 0);
        push_seq(6'h2B, 5, 0, 0, 0); push_seq(6'h2B, 5, 0, 0, 0); push_seq(6'h2B, 5, 0, 1, 0);
        push_seq(6'h2B, 0, 0, 0, 0);

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("reset0_c%0d", i), 32'(act0),
                32'({4'd0, 5'b00000, 4'b0000, 2'b01, 2'b00, 1'b0, 3'b010}));
            chk($sformatf("reset2_c%0d", i),
                32'({State2, IRWrite2, PCEn2, MemWrite2, RegWrite2}), 32'h0);
        end

        // Vector table on the MEM_LAT=0 instance; reset released at entry 0
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst    = 1'b0;
            Opcode = tbl[i].op;
            Funct  = tbl[i].fn;
            Zero   = tbl[i].z;
            #1;
            chk($sformatf("vec%0d", i), 32'(act0), 32'(tbl[i].exp));
        end

        // Wait-state sequences on the MEM_LAT=2 instance
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_reset2_state", 32'(State2), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        Funct = 6'h00;
        Zero  = 1'b0;
        for (int i = 0; i < seq.size(); i++) begin
            if (i > 0) @(negedge clk);
            Opcode = seq[i].op;
            #1;
            chk($sformatf("lat2_%0d_state", i), 32'(State2), 32'(seq[i].st));
            chk($sformatf("lat2_%0d_irw_pcen", i), 32'({IRWrite2, PCEn2}),
                32'({seq[i].irw, seq[i].irw}));
            chk($sformatf("lat2_%0d_mw", i), 32'(MemWrite2), 32'(seq[i].mw));
            chk($sformatf("lat2_%0d_rw_m2r", i), 32'({RegWrite2, MemtoReg2}),
                32'({seq[i].rw, seq[i].rw}));
        end

        // sw interrupted by reset in the middle of the MEMWR wait
        Opcode = 6'h2B;
        repeat (6) @(negedge clk);
        #1;
        chk("midrst_pre_state", 32'(State2), 32'd5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_state", 32'(State2), 32'd0);
        chk("midrst_strobes", 32'({MemWrite2, RegWrite2, IRWrite2, PCEn2}), 32'h0);
        @(negedge clk);
        #1;
        chk("midrst_hold_mw", 32'(MemWrite2), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_release_state", 32'(State2), 32'd0);
        chk("midrst_release_irw", 32'(IRWrite2), 32'd0);
        @(negedge clk);
        #1;
        chk("midrst_cnt_cleared", 32'({State2, IRWrite2}), 32'h0);
        @(negedge clk);
        #1;
        chk("midrst_fetch_last", 32'({State2, IRWrite2}), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
